// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window controller: default geometry,
// sequencer states and counter-width helpers.
package sobel_pkg;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Column counter width for an image row of img_w pixels.
    function automatic int col_w(input int img_w);
        return cnt_w(img_w);
    endfunction

    // Row counter width for an image of img_h rows.
    function automatic int row_w(input int img_h);
        return cnt_w(img_h);
    endfunction

    // Result address width: one address per interior window centre.
    function automatic int addr_w(input int img_w, input int img_h);
        return cnt_w((img_w - 2) * (img_h - 2));
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two line buffers of IMG_W pixels addressed by column. lb1 holds the previous
// row, lb0 the row before that. On a write both rows slide down by one line at
// the addressed column in a single cycle. Reads are asynchronous so the window
// can capture the column in the same cycle the pixel is accepted; storage is
// deliberately not reset.
module sobel_line_buffer #(
    parameter int IMG_W = 640,
    parameter int COL_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [COL_W-1:0] col,
    input  logic [7:0]       din,
    output logic [7:0]       lb0_q,
    output logic [7:0]       lb1_q
);

    logic [7:0] lb0_mem [IMG_W];
    logic [7:0] lb1_mem [IMG_W];

    assign lb0_q = lb0_mem[col];
    assign lb1_q = lb1_mem[col];

    // Shift the column down one line: older row takes the previous row, newest takes the pixel.
    always_ff @(posedge clk) begin
        if (we) begin
            lb0_mem[col] <= lb1_mem[col];
            lb1_mem[col] <= din;
        end
    end

endmodule

// File: rtl/sobel_win_ctrl.sv
// Frame sequencer for the 3x3 Sobel core: builds the sliding window from a
// raster pixel stream, strobes the core for interior centres only, and writes
// the core's results out with a linear result address.
module sobel_win_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = addr_w(IMG_W, IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_data_i,
    output logic [7:0]        win_0_0_o,
    output logic [7:0]        win_0_1_o,
    output logic [7:0]        win_0_2_o,
    output logic [7:0]        win_1_0_o,
    output logic [7:0]        win_1_1_o,
    output logic [7:0]        win_1_2_o,
    output logic [7:0]        win_2_0_o,
    output logic [7:0]        win_2_1_o,
    output logic [7:0]        win_2_2_o,
    output logic              core_en_o,
    input  logic [7:0]        core_pixel_i,
    input  logic              core_pixel_en_i,
    output logic              res_valid_o,
    output logic [7:0]        res_data_o,
    output logic [ADDR_W-1:0] res_addr_o
);

    localparam int COL_W = col_w(IMG_W);
    localparam int ROW_W = row_w(IMG_H);
    localparam int TOTAL = (IMG_W - 2) * (IMG_H - 2);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0]  ROW_TWO  = ROW_W'(2);
    localparam logic [ADDR_W-1:0] RES_LAST = ADDR_W'(TOTAL - 1);

    state_t            state_reg, state_next;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;
    logic              core_en_reg;
    logic              res_valid_reg;
    logic [7:0]        res_data_reg;
    logic [ADDR_W-1:0] res_addr_reg;
    logic [ADDR_W-1:0] res_cnt_reg;
    logic              done_reg;

    logic              accept;
    logic              last_pix;
    logic              res_take;
    logic              res_last;
    logic [7:0]        lb0_q, lb1_q;
    logic [2:0][7:0]   col_in;

    assign in_ready_o = (state_reg == RUN);
    assign busy_o     = (state_reg != IDLE);
    assign accept     = in_valid_i && in_ready_o;
    assign last_pix   = accept && (col_reg == COL_LAST) && (row_reg == ROW_LAST);
    // Late core results are still taken while flushing; anything in IDLE is stray.
    assign res_take   = core_pixel_en_i && (state_reg != IDLE);
    assign res_last   = res_take && (res_cnt_reg == RES_LAST);

    // Column entering each window row: oldest row from lb0, newest from the stream.
    assign col_in = {in_data_i, lb1_q, lb0_q};

    sobel_line_buffer #(
        .IMG_W (IMG_W),
        .COL_W (COL_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (accept),
        .col   (col_reg),
        .din   (in_data_i),
        .lb0_q (lb0_q),
        .lb1_q (lb1_q)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: frame runs until the last pixel, then drains until done.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i)  state_next = RUN;
            RUN:     if (last_pix) state_next = FLUSH;
            FLUSH:   if (done_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Raster position of the next pixel to be accepted; wraps to 0,0 at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (col_reg == COL_LAST) begin
                col_reg <= '0;
                row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // One shift register per window row; taps hold when no pixel is accepted.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [2:0][7:0] tap_reg;

        // Slide the row left and load the new column on each accepted pixel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tap_reg <= '0;
            end else if (accept) begin
                tap_reg[0] <= tap_reg[1];
                tap_reg[1] <= tap_reg[2];
                tap_reg[2] <= col_in[gi];
            end
        end
    end

    assign win_0_0_o = g_row[0].tap_reg[0];
    assign win_0_1_o = g_row[0].tap_reg[1];
    assign win_0_2_o = g_row[0].tap_reg[2];
    assign win_1_0_o = g_row[1].tap_reg[0];
    assign win_1_1_o = g_row[1].tap_reg[1];
    assign win_1_2_o = g_row[1].tap_reg[2];
    assign win_2_0_o = g_row[2].tap_reg[0];
    assign win_2_1_o = g_row[2].tap_reg[1];
    assign win_2_2_o = g_row[2].tap_reg[2];

    // Strobe the core only when the accepted pixel completes an interior window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_en_reg <= 1'b0;
        end else begin
            core_en_reg <= accept && (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);
        end
    end

    assign core_en_o = core_en_reg;

    // Register core results with their linear address; the last one raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_addr_reg  <= '0;
            res_cnt_reg   <= '0;
            done_reg      <= 1'b0;
        end else begin
            res_valid_reg <= res_take;
            done_reg      <= res_last;
            if (res_take) begin
                res_data_reg <= core_pixel_i;
                res_addr_reg <= res_cnt_reg;
                res_cnt_reg  <= res_last ? '0 : res_cnt_reg + 1'b1;
            end
        end
    end

    assign res_valid_o = res_valid_reg;
    assign res_data_o  = res_data_reg;
    assign res_addr_o  = res_addr_reg;
    assign done_o      = done_reg;

endmodule

// File: tb/tb_sobel_win_ctrl.sv
// Scoreboard bench for sobel_win_ctrl on a 5x4 image. Expected windows and
// results are derived from whole-frame pixel arrays; a bench-side Sobel core
// answers core_en_o two cycles after the accepting edge.
module tb_sobel_win_ctrl;

    localparam int W     = 5;
    localparam int H     = 4;
    localparam int AW    = 3;
    localparam int TOTAL = (W - 2) * (H - 2);
    localparam int THR   = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [7:0]    in_data_i = 8'h00;
    logic [7:0]    win_0_0_o, win_0_1_o, win_0_2_o;
    logic [7:0]    win_1_0_o, win_1_1_o, win_1_2_o;
    logic [7:0]    win_2_0_o, win_2_1_o, win_2_2_o;
    logic          core_en_o;
    logic [7:0]    core_pixel_i;
    logic          core_pixel_en_i;
    logic          res_valid_o;
    logic [7:0]    res_data_o;
    logic [AW-1:0] res_addr_o;

    logic          model_en = 1'b0;
    logic [7:0]    model_pix = 8'h00;
    logic          inj_en = 1'b0;

    assign core_pixel_en_i = model_en | inj_en;
    assign core_pixel_i    = inj_en ? 8'hA5 : model_pix;

    sobel_win_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .win_0_0_o       (win_0_0_o),
        .win_0_1_o       (win_0_1_o),
        .win_0_2_o       (win_0_2_o),
        .win_1_0_o       (win_1_0_o),
        .win_1_1_o       (win_1_1_o),
        .win_1_2_o       (win_1_2_o),
        .win_2_0_o       (win_2_0_o),
        .win_2_1_o       (win_2_1_o),
        .win_2_2_o       (win_2_2_o),
        .core_en_o       (core_en_o),
        .core_pixel_i    (core_pixel_i),
        .core_pixel_en_i (core_pixel_en_i),
        .res_valid_o     (res_valid_o),
        .res_data_o      (res_data_o),
        .res_addr_o      (res_addr_o)
    );

    always #5 clk = ~clk;

    // Taps packed so that tap (r,c) sits at bits [(r*3+c)*8 +: 8].
    wire [71:0] taps = {win_2_2_o, win_2_1_o, win_2_0_o,
                        win_1_2_o, win_1_1_o, win_1_0_o,
                        win_0_2_o, win_0_1_o, win_0_0_o};

    int         pix [H][W];
    logic [71:0] exp_win_q [$];
    logic [7:0]  exp_data_q [$];
    int          exp_addr_q [$];

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int core_en_cnt = 0;
    int last_acc_cyc = 0;
    int last_en_cyc = 0;
    int done_cyc = 0;
    bit done_seen = 0;
    bit done_prev = 0;
    bit acc_prev = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Sobel magnitude threshold computed straight from the frame array around (cy,cx).
    function automatic logic [7:0] ref_edge(input int cy, input int cx);
        int gx, gy, wt;
        gx = 0;
        gy = 0;
        for (int d = -1; d <= 1; d++) begin
            wt = (d == 0) ? 2 : 1;
            gx += wt * (pix[cy+d][cx+1] - pix[cy+d][cx-1]);
            gy += wt * (pix[cy+1][cx+d] - pix[cy-1][cx+d]);
        end
        return (iabs(gx) + iabs(gy) >= THR) ? 8'hFF : 8'h00;
    endfunction

    // Bench-side core: the same operator applied to whatever taps the DUT presents.
    function automatic logic [7:0] core_fn(input logic [71:0] w);
        int t [3][3];
        int gx, gy;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                t[r][c] = int'(w[(r*3+c)*8 +: 8]);
        gx = (t[0][2] + 2*t[1][2] + t[2][2]) - (t[0][0] + 2*t[1][0] + t[2][0]);
        gy = (t[2][0] + 2*t[2][1] + t[2][2]) - (t[0][0] + 2*t[0][1] + t[0][2]);
        return (iabs(gx) + iabs(gy) >= THR) ? 8'hFF : 8'h00;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: capture the strobe mid-cycle, answer just after the next edge.
    bit         cap_en = 0;
    logic [7:0] cap_pix = 8'h00;
    always @(negedge clk) begin
        cap_en  = core_en_o && rst_n;
        cap_pix = core_fn(taps);
    end
    always @(posedge clk) begin
        #1;
        model_en  = cap_en && rst_n;
        model_pix = cap_pix;
    end

    // Monitor: pops expectations whenever the DUT strobes the core or writes a result.
    logic [71:0] m_win;
    logic [7:0]  m_data;
    int          m_addr;
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_prev  = 0;
            done_prev = 0;
        end else begin
            if (done_prev) check("busy_after_done", 72'(busy_o), 72'(0));
            done_prev = 0;
            if (core_en_o) begin
                check("core_en_follows_accept", 72'(acc_prev), 72'(1));
                core_en_cnt++;
                last_en_cyc = cyc;
                if (exp_win_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_core_en: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    m_win = exp_win_q.pop_front();
                    check("window_taps", taps, m_win);
                end
            end
            if (res_valid_o) begin
                if (exp_data_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_result: got data %0h addr %0d, expected none", res_data_o, res_addr_o);
                end else begin
                    m_data = exp_data_q.pop_front();
                    m_addr = exp_addr_q.pop_front();
                    check("res_data", 72'(res_data_o), 72'(m_data));
                    check("res_addr", 72'(res_addr_o), 72'(m_addr));
                    check("done_with_result", 72'(done_o), 72'(m_addr == TOTAL - 1));
                end
            end else if (done_o) begin
                n_vec++; n_fail++;
                $display("FAIL done_without_result: got done 1, expected 0");
            end
            if (done_o) begin
                done_prev = 1;
                done_seen = 1;
                done_cyc  = cyc;
            end
            acc_prev = in_valid_i && in_ready_o;
            if (acc_prev) last_acc_cyc = cyc;
        end
    end

    task automatic push_expect();
        logic [71:0] w;
        int k;
        k = 0;
        for (int cy = 1; cy < H - 1; cy++) begin
            for (int cx = 1; cx < W - 1; cx++) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        w[(r*3+c)*8 +: 8] = 8'(pix[cy-1+r][cx-1+c]);
                exp_win_q.push_back(w);
                exp_data_q.push_back(ref_edge(cy, cx));
                exp_addr_q.push_back(k);
                k++;
            end
        end
        $display("frame queued: %0d expected results", k);
    endtask

    task automatic fill(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0:       pix[y][x] = 100;
                    1:       pix[y][x] = (x >= 2) ? 255 : 0;
                    default: pix[y][x] = int'($urandom_range(0, 150));
                endcase
    endtask

    // Issue one full frame; max_gap>0 inserts random idle cycles between pixels.
    task automatic drive_frame(input int max_gap, input bit poke_start);
        bit acc;
        int gap;
        core_en_cnt = 0;
        done_seen   = 0;
        push_expect();
        @(posedge clk); #1;
        start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                repeat (gap) begin
                    in_valid_i = 0;
                    in_data_i  = 8'($urandom);
                    @(posedge clk); #1;
                end
                in_valid_i = 1;
                in_data_i  = 8'(pix[y][x]);
                if (poke_start && y == 1 && x == 2) start_i = 1;
                acc = 0;
                for (int k = 0; k < 20 && !acc; k++) begin
                    @(negedge clk);
                    acc = in_ready_o;
                    @(posedge clk); #1;
                    start_i = 0;
                end
                if (!acc) begin
                    n_vec++; n_fail++;
                    $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted", y, x);
                    in_valid_i = 0;
                    return;
                end
            end
        end
        // Now in the cycle after the last accept: controller must be draining.
        in_valid_i = 1;
        in_data_i  = 8'h5A;
        if (poke_start) start_i = 1;
        check("in_ready_in_flush", 72'(in_ready_o), 72'(0));
        check("busy_in_flush", 72'(busy_o), 72'(1));
        @(posedge clk); #1;
        start_i    = 0;
        in_valid_i = 0;
        for (int k = 0; k < 40 && !done_seen; k++) begin
            @(posedge clk); #1;
        end
        if (!done_seen) begin
            n_vec++; n_fail++;
            $display("FAIL done_timeout: got no done, expected done");
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("core_en_count", 72'(core_en_cnt), 72'(TOTAL));
        check("results_drained", 72'(exp_data_q.size()), 72'(0));
        check("last_core_en_latency", 72'(last_en_cyc - last_acc_cyc), 72'(1));
        check("done_latency", 72'(done_cyc - last_acc_cyc), 72'(3));
        check("idle_after_frame", 72'(busy_o), 72'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      72'(busy_o),      72'(0));
        check({tag, "_done"},      72'(done_o),      72'(0));
        check({tag, "_in_ready"},  72'(in_ready_o),  72'(0));
        check({tag, "_core_en"},   72'(core_en_o),   72'(0));
        check({tag, "_res_valid"}, 72'(res_valid_o), 72'(0));
        check({tag, "_res_data"},  72'(res_data_o),  72'(0));
        check({tag, "_res_addr"},  72'(res_addr_o),  72'(0));
        check({tag, "_taps"},      taps,             72'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // Idle: offered pixels are refused, stray core results are ignored.
        @(posedge clk); #1;
        in_valid_i = 1;
        in_data_i  = 8'h33;
        inj_en     = 1;
        @(negedge clk);
        check("in_ready_idle", 72'(in_ready_o), 72'(0));
        @(posedge clk); #1;
        inj_en = 0;
        @(negedge clk);
        check("no_result_in_idle", 72'(res_valid_o), 72'(0));
        check("busy_idle", 72'(busy_o), 72'(0));
        @(posedge clk); #1;
        in_valid_i = 0;

        fill(0); drive_frame(0, 0);
        fill(1); drive_frame(0, 0);
        fill(1); drive_frame(3, 1);
        for (int f = 0; f < 3; f++) begin
            fill(2);
            drive_frame(3, f[0]);
        end

        // Abort a frame after 9 pixels with reset, then run a clean frame.
        @(posedge clk); #1;
        start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        for (int i = 0; i < 9; i++) begin
            in_valid_i = 1;
            in_data_i  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid_i = 0;
        rst_n = 0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        fill(1); drive_frame(0, 0);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_win_ctrl.md
Name: sobel_win_ctrl

Overview:
- Frame-level sequencer that feeds the 3x3 Sobel edge core from a raster-order 8-bit pixel stream.
- Holds two line buffers and a 3x3 window register, and pulses the core enable only for interior window positions.
- Collects the core's 1-bit-per-pixel edge result (0x00/0xFF) and emits it with a linear address into the result memory.
- Signals start, busy and done to the host sequencer.

Parameters:
- IMG_W, 640, image width in pixels (>=3)
- IMG_H, 480, image height in pixels (>=3)
- ADDR_W, $clog2((IMG_W-2)*(IMG_H-2)), result address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  frame start pulse; ignored unless IDLE
- busy_o  out  1  high while not IDLE
- done_o  out  1  single-cycle pulse with last result
- in_valid_i  in  1  input pixel valid
- in_ready_o  out  1  controller accepts pixel (high only in RUN)
- in_data_i  in  8  input pixel
- win_r_c_o (r,c in 0..2, 9 ports)  out  8  window taps to core; r0 = oldest row, c0 = oldest column
- core_en_o  out  1  window valid strobe to core
- core_pixel_i  in  8  core result
- core_pixel_en_i  in  1  core result valid
- res_valid_o  out  1  result write strobe
- res_data_o  out  8  result pixel
- res_addr_o  out  ADDR_W  result linear address

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; col/row/result counters 0. Line-buffer storage is not reset; its contents are never consumed while core_en_o is low.
- FSM states and transitions:
  - IDLE: start_i -> RUN.
  - RUN: the accept of pixel (IMG_H-1, IMG_W-1) -> FLUSH.
  - FLUSH: in_ready_o=0; the cycle done_o is asserted -> IDLE.
- Accept condition: in_valid_i && in_ready_o. Data is consumed only on accept; gaps in in_valid_i stall the sequencer with no loss.
- On accept of pixel (y,x):
  - Each window row shifts left: c0<=c1, c1<=c2.
  - New column: win_2_2<=in_data_i; win_1_2<=lb1[x]; win_0_2<=lb0[x].
  - Line-buffer update: lb0[x]<=lb1[x]; lb1[x]<=in_data_i.
  - x increments and wraps at IMG_W-1 to 0 with y++. Wrap of y ends the frame.
- core_en_o (registered) = accept && y>=2 && x>=2. It is high exactly one cycle per interior window. Taps hold their values when there is no accept.
- Latency:
  - Pixel accepted in cycle t -> core_en_o in t+1.
  - Core result expected in t+2.
  - res_valid_o/res_data_o registered from core_pixel_en_i/core_pixel_i, so the result appears in t+3.
- res_addr_o = count of prior results: starts at 0 per frame and increments after each res_valid_o. Total results per frame = (IMG_W-2)*(IMG_H-2). Result order is raster over interior centres.
- done_o is asserted in the same cycle as the final res_valid_o.
  - busy_o drops in the following cycle.
  - The result counter clears on done.
- Border pixels produce no result, with no padding.
- start_i outside IDLE has no effect. in_valid_i in IDLE/FLUSH is not accepted.
- core_pixel_en_i outside RUN/FLUSH is ignored (no res_valid_o).
- Reset asserted mid-frame: immediate return to IDLE, all outputs 0, partial frame discarded. The next start_i begins a clean frame.

Decomposition:
- Shared package sobel_pkg contains:
  - default IMG_W/IMG_H
  - state enum {IDLE, RUN, FLUSH}
  - width helper functions for the col/row/address counters
- Sub-module sobel_line_buffer holds the two IMG_W x 8 line buffers:
  - one read/write port pair indexed by column
  - returns lb0[x]/lb1[x] and writes the shifted values in the same cycle
  - inferable as RAM or registers

Test Plan:
- IMG_W=5, IMG_H=4, all pixels 100, in_valid continuous -> 6 results, all 0x00, addr 0..5; done_o with addr 5; busy_o low the next cycle.
- IMG_W=5, IMG_H=4, columns 0-1 = 0 and columns 2-4 = 255 -> each interior row yields FF, FF, 00 (|gx|=1020, 1020, 0); 6 results.
- Same image with random 0-3 cycle in_valid gaps -> identical result sequence. core_en_o is never high unless a pixel was accepted the previous cycle, and is high exactly 6 times.
- Latency check: last pixel accepted in cycle t -> final core_en_o in t+1, final res_valid_o and done_o in t+3.
- start_i pulsed during RUN and FLUSH -> no state change or counter reset. in_ready_o is 0 before start_i and in FLUSH.
- rst_n asserted after 9 pixels of a frame -> all outputs 0 and FSM in IDLE. A fresh start_i plus the full vertical-edge frame -> correct 6 results starting at addr 0.
